// File: rtl/alu_seq_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_param_if
//  Description : Operand/result bus for the sequential ALU. The master side
//                drives operands and opcode; the slave side returns the result,
//                the remainder, the flags and the handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_param_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             out_valid;
  logic [WIDTH-1:0] ALU_OUT;
  logic [WIDTH-1:0] REM_OUT;
  logic             Carry_Flag;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  logic             Div0_Flag;

  modport master (
    output in_valid, A, B, ALU_FUN,
    input  in_ready, out_valid, ALU_OUT, REM_OUT,
    input  Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Div0_Flag
  );

  modport slave (
    input  in_valid, A, B, ALU_FUN,
    output in_ready, out_valid, ALU_OUT, REM_OUT,
    output Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Div0_Flag
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_param
//  Description : Registered ALU with valid/ready operand handshake. Every op
//                except a non-zero divide completes one cycle after issue; the
//                divide runs a WIDTH-cycle restoring divider, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_param #(
  parameter int WIDTH     = 16,
  parameter int SHIFT_VAR = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_seq_param_if.slave       bus
);

  localparam int c_sw = $clog2(WIDTH);

  localparam logic [3:0] c_op_add  = 4'h0;
  localparam logic [3:0] c_op_sub  = 4'h1;
  localparam logic [3:0] c_op_mul  = 4'h2;
  localparam logic [3:0] c_op_div  = 4'h3;
  localparam logic [3:0] c_op_and  = 4'h4;
  localparam logic [3:0] c_op_or   = 4'h5;
  localparam logic [3:0] c_op_nand = 4'h6;
  localparam logic [3:0] c_op_nor  = 4'h7;
  localparam logic [3:0] c_op_xor  = 4'h8;
  localparam logic [3:0] c_op_xnor = 4'h9;
  localparam logic [3:0] c_op_eq   = 4'hA;
  localparam logic [3:0] c_op_gt   = 4'hB;
  localparam logic [3:0] c_op_lt   = 4'hC;
  localparam logic [3:0] c_op_shr  = 4'hD;
  localparam logic [3:0] c_op_shl  = 4'hE;
  localparam logic [3:0] c_op_asr  = 4'hF;

  localparam logic [c_sw-1:0] c_cnt_last = c_sw'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t           r_state;
  logic [c_sw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_quo;      // dividend shifting out MSB-first, quotient shifting in
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_div;      // latched divisor

  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_carry;
  logic             r_arith;
  logic             r_logic;
  logic             r_cmp;
  logic             r_shift;
  logic             r_div0;

  logic [c_sw-1:0]  w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_mul;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_div0;
  logic             w_arith;
  logic             w_logic;
  logic             w_cmp;
  logic             w_shift;
  logic             w_div_start;

  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // Shift amount: low bits of B when variable, otherwise a constant single step
  generate
    if (SHIFT_VAR != 0) begin : g_shamt_var
      assign w_shamt = bus.B[c_sw-1:0];
    end else begin : g_shamt_fixed
      assign w_shamt = c_sw'(1);
    end
  endgenerate

  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_mul  = bus.A * bus.B;

  assign w_arith = (bus.ALU_FUN <= c_op_div);
  assign w_logic = (bus.ALU_FUN >= c_op_and) && (bus.ALU_FUN <= c_op_xnor);
  assign w_cmp   = (bus.ALU_FUN >= c_op_eq)  && (bus.ALU_FUN <= c_op_lt);
  assign w_shift = (bus.ALU_FUN >= c_op_shr);

  assign w_div_start = bus.in_valid && (bus.ALU_FUN == c_op_div) && (bus.B != '0);

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  // The top bit of the (WIDTH+1)-bit difference is set exactly when it does not.
  assign w_sub     = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
  assign w_ge      = ~w_sub[WIDTH];
  assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Single-cycle result, carry and divide-by-zero decode
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_div0  = 1'b0;
    case (bus.ALU_FUN)
      c_op_add:  begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      c_op_sub:  begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      c_op_mul:  w_res = w_mul;
      c_op_div:  w_div0 = (bus.B == '0);
      c_op_and:  w_res = bus.A & bus.B;
      c_op_or:   w_res = bus.A | bus.B;
      c_op_nand: w_res = ~(bus.A & bus.B);
      c_op_nor:  w_res = ~(bus.A | bus.B);
      c_op_xor:  w_res = bus.A ^ bus.B;
      c_op_xnor: w_res = ~(bus.A ^ bus.B);
      c_op_eq:   w_res = (bus.A == bus.B) ? WIDTH'(1) : '0;
      c_op_gt:   w_res = (bus.A >  bus.B) ? WIDTH'(2) : '0;
      c_op_lt:   w_res = (bus.A <  bus.B) ? WIDTH'(3) : '0;
      c_op_shr:  w_res = bus.A >> w_shamt;
      c_op_shl:  w_res = bus.A << w_shamt;
      c_op_asr:  w_res = WIDTH'($signed(bus.A) >>> w_shamt);
      default:   w_res = '0;
    endcase
  end

  // FSM, divider datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_rem_out   <= '0;
      r_carry     <= 1'b0;
      r_arith     <= 1'b0;
      r_logic     <= 1'b0;
      r_cmp       <= 1'b0;
      r_shift     <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_div_start) begin
            r_state <= S_DIV;
            r_quo   <= bus.A;
            r_div   <= bus.B;
            r_rem   <= '0;
            r_cnt   <= '0;
          end else if (bus.in_valid) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_res;
            r_rem_out   <= '0;
            r_carry     <= w_carry;
            r_arith     <= w_arith;
            r_logic     <= w_logic;
            r_cmp       <= w_cmp;
            r_shift     <= w_shift;
            r_div0      <= w_div0;
          end
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + c_sw'(1);
          if (r_cnt == c_cnt_last) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b1;
            r_alu_out   <= w_quo_nxt;
            r_rem_out   <= w_rem_nxt;
            r_carry     <= 1'b0;
            r_arith     <= 1'b1;
            r_logic     <= 1'b0;
            r_cmp       <= 1'b0;
            r_shift     <= 1'b0;
            r_div0      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.ALU_OUT    = r_alu_out;
  assign bus.REM_OUT    = r_rem_out;
  assign bus.Carry_Flag = r_carry;
  assign bus.Arith_Flag = r_arith;
  assign bus.Logic_Flag = r_logic;
  assign bus.CMP_Flag   = r_cmp;
  assign bus.Shift_Flag = r_shift;
  assign bus.Div0_Flag  = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_param
//  Description : Directed self-checking bench for alu_seq_param (WIDTH=16,
//                variable shifts). Flags are compared as one vector
//                {Carry, Arith, Logic, CMP, Shift, Div0}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_param;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_seq_param_if #(.WIDTH(16)) bus ();

  alu_seq_param #(.WIDTH(16), .SHIFT_VAR(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] flags;
  assign flags = {bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag,
                  bus.CMP_Flag, bus.Shift_Flag, bus.Div0_Flag};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op for one edge, then sample just after that edge
  task automatic issue(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.ALU_FUN  = fun;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Issue a non-zero divide, keep offering (ignored) ops while busy, measure latency
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r);
    int cyc;
    int busy;
    issue(4'h3, a, b);
    busy = bus.in_ready ? 0 : 1;
    bus.in_valid = 1'b1;
    bus.ALU_FUN  = 4'h0;
    bus.A        = 16'h1111;
    bus.B        = 16'h2222;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!bus.in_ready) busy++;
    end while (!bus.out_valid && cyc < 40);
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'd16);
    check({tag, "_busy_cycles"}, 32'(busy), 32'd16);
    check({tag, "_quot"}, 32'(bus.ALU_OUT), 32'(q));
    check({tag, "_rem"}, 32'(bus.REM_OUT), 32'(r));
    check({tag, "_flags"}, 32'(flags), 32'b010000);
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.ALU_FUN  = 4'h0;
    bus.A        = '0;
    bus.B        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.ALU_OUT), 32'd0);
    check("rst_rem", 32'(bus.REM_OUT), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with carry-out
    issue(4'h0, 16'hFFFF, 16'h0001);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_out", 32'(bus.ALU_OUT), 32'h0000);
    check("add_flags", 32'(flags), 32'b110000);

    // Idle cycle: pulse drops, result holds
    @(posedge clk);
    #1;
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_flags_hold", 32'(flags), 32'b110000);

    // SUB with borrow followed back-to-back by GT
    issue(4'h1, 16'd3, 16'd5);
    check("sub_out", 32'(bus.ALU_OUT), 32'hFFFE);
    check("sub_flags", 32'(flags), 32'b110000);
    issue(4'hB, 16'd9, 16'd4);
    check("gt_valid", 32'(bus.out_valid), 32'd1);
    check("gt_out", 32'(bus.ALU_OUT), 32'd2);
    check("gt_flags", 32'(flags), 32'b000100);
    check("gt_ready", 32'(bus.in_ready), 32'd1);

    // Remaining arithmetic / logic / compare patterns
    issue(4'h2, 16'd300, 16'd300);
    check("mul_out", 32'(bus.ALU_OUT), 32'h5F90);
    check("mul_flags", 32'(flags), 32'b010000);
    issue(4'h6, 16'hF0F0, 16'hFF00);
    check("nand_out", 32'(bus.ALU_OUT), 32'h0FFF);
    check("nand_flags", 32'(flags), 32'b001000);
    issue(4'h9, 16'h1234, 16'h00FF);
    check("xnor_out", 32'(bus.ALU_OUT), 32'hED34);
    issue(4'hA, 16'd5, 16'd5);
    check("eq_out", 32'(bus.ALU_OUT), 32'd1);
    issue(4'hB, 16'd1, 16'd2);
    check("gt_false_out", 32'(bus.ALU_OUT), 32'd0);
    issue(4'hC, 16'd1, 16'd2);
    check("lt_out", 32'(bus.ALU_OUT), 32'd3);

    // Divide 100 / 7
    run_div("div100_7", 16'd100, 16'd7, 16'd14, 16'd2);
    @(posedge clk);
    #1;
    check("div_pulse_drop", 32'(bus.out_valid), 32'd0);
    check("div_hold", 32'(bus.ALU_OUT), 32'd14);

    // Divide by zero is single-cycle
    issue(4'h3, 16'd5, 16'd0);
    check("div0_valid", 32'(bus.out_valid), 32'd1);
    check("div0_out", 32'(bus.ALU_OUT), 32'd0);
    check("div0_rem", 32'(bus.REM_OUT), 32'd0);
    check("div0_flags", 32'(flags), 32'b010001);
    check("div0_ready", 32'(bus.in_ready), 32'd1);

    // Shifts; upper bits of B beyond the shift field are ignored
    issue(4'hF, 16'h8000, 16'h0013);
    check("asr_out", 32'(bus.ALU_OUT), 32'hF000);
    check("asr_flags", 32'(flags), 32'b000010);
    issue(4'hD, 16'h8000, 16'd3);
    check("shr_out", 32'(bus.ALU_OUT), 32'h1000);
    issue(4'hE, 16'h0001, 16'd15);
    check("shl_out", 32'(bus.ALU_OUT), 32'h8000);

    // Reset in the middle of a divide aborts it
    issue(4'h3, 16'hFFFF, 16'd3);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out", 32'(bus.ALU_OUT), 32'd0);
    check("abort_rem", 32'(bus.REM_OUT), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);

    // A fresh divide after the abort
    run_div("div1000_33", 16'd1000, 16'd33, 16'd30, 16'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
